pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard controller for the five-stage MIPS pipeline. It generates the E-stage and D-stage forwarding selects and the load-use and branch/jr stall conditions. It also adds a counter-based stall FSM that holds the pipeline while a multi-cycle divide occupies the E stage, and an exception flush that overrides all stalls. It sits between `datapath` and `controller`, taking pipeline register addresses and control bits and returning stall/flush/forward controls.

## Interface
- `REG_AW`, 5, register address width
- `DIV_CYCLES`, 32, E-stage stall cycles per divide (≥2)
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rsD`, `rtD`  in  REG_AW  D-stage source registers
- `rsE`, `rtE`  in  REG_AW  E-stage source registers
- `writeregE`, `writeregM`, `writeregW`  in  REG_AW  destination per stage
- `regwriteE`, `regwriteM`, `regwriteW`  in  1  write-enable per stage
- `memtoregE`, `memtoregM`  in  1  load in stage
- `branchD`, `jrD`  in  1  D-stage instruction compares/reads rs (and rt for branch)
- `divE`  in  1  divide instruction in E
- `excflush`  in  1  exception flush request
- `forwardaD`, `forwardbD`  out  1  select M-stage result for D compare
- `forwardaE`, `forwardbE`  out  2  00 regfile, 01 W result, 10 M result
- `stallF`, `stallD`, `stallE`  out  1  hold stage register
- `flushE`, `flushM`  out  1  bubble into stage register
- `div_start`  out  1  one-cycle start pulse to divider
- `div_done`  out  1  divider result valid this cycle; E advances
- `lwstallD`, `branchstallD`, `divstallE`  out  1  raw stall causes (debug)

## Operation
- Register 0 never matches: every compare below requires address ≠ 0.
- forwardaE: 10 if `regwriteM` && `writeregM`==`rsE`; else 01 if `regwriteW` && `writeregW`==`rsE`; else 00. forwardbE uses `rtE`. M has priority over W.
- forwardaD / forwardbD: `regwriteM` && `writeregM`==`rsD` / `rtD`.
- lwstallD: `memtoregE` && `regwriteE` && `writeregE` ∈ {`rsD`,`rtD`}.
- branchstallD: (`branchD`||`jrD`) && ((`regwriteE` && `writeregE` ∈ {rsD,rtD}) || (`memtoregM` && `writeregM` ∈ {rsD,rtD})). For `jrD`, only rsD is checked.
- Divide FSM, states IDLE / BUSY, 
  - `cnt` is $clog2(DIV_CYCLES) bits.
  - IDLE && `divE`: pulse `div_start`, load `cnt`=DIV_CYCLES-1, go BUSY.
  - BUSY && `cnt`≠0: decrement `cnt`.
  - BUSY && `cnt`==0: `div_done`=1, go IDLE.
- divstallE = `divE` && (IDLE || `cnt`≠0).
- Priority: `excflush` > divide stall > lw/branch stall.
  - `excflush`: FSM → IDLE, `flushE`=`flushM`=1, all stalls 0, `div_start`=0.
  - divstallE: `stallF`=`stallD`=`stallE`=1, `flushM`=1, `flushE`=0. E holds; M receives bubbles.
  - else lw|branch: `stallF`=`stallD`=1, `flushE`=1.
- `divE` dropping while BUSY (not normal use): return to IDLE next cycle, no `div_done`.

## Timing
- Forwarding and stall/flush outputs are combinational from inputs and current FSM state.
- FSM and `cnt` update on `clk` rising edge.
- Reset: state IDLE, `cnt`=0. With inputs low, all outputs are 0 and forward selects are 00.
- A divide is stalled for exactly DIV_CYCLES cycles. It advances on cycle DIV_CYCLES+1, with `div_done` high in that cycle.
- A divide in E the cycle after `div_done` starts a new operation immediately (back-to-back).
- `rst` or `excflush` mid-divide aborts it and takes effect on the same edge.

## Configuration
- `HAZARD_PERF_EN` defined: three 32-bit saturating counters `perf_lw`, `perf_br`, `perf_div` are added as outputs.
  - Each increments once per cycle its stall cause is actually applied after priority resolution.
  - All three clear on `rst`.
- Undefined: no counters, no ports, no logic.

## Structure
- Shared package `hazard_pkg`: forward-select constants `FWD_REG`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10, and enum `div_state_t` {IDLE, BUSY}.
- Sub-module `div_stall_fsm`: counter and FSM, with inputs `divE` and `excflush` and outputs `div_start`, `div_done`, `divstallE`.

## Test plan
- Load-use: lw to r8 in E, r8 as rsD → `stallF`=`stallD`=`flushE`=1 for one cycle, then `forwardaE`=10.
- Forward priority: M and W both write r3, rsE=3 → `forwardaE`=10. Same case with rsE=0 → 00.
- Branch on r5 while E writes r5 → `branchstallD`=1. Next cycle with r5 in M → `forwardaD`=1 and no stall.
- Divide with DIV_CYCLES=4: `divE` held → `div_start` pulses in cycle 0, stalls in cycles 0–3, `div_done` in cycle 4, `flushM`=1 in cycles 0–3. Back-to-back divide → next `div_start` in cycle 5.
- `excflush` in cycle 2 of a divide → stalls drop that cycle and FSM is IDLE next cycle. Same check with `rst` in cycle 2 instead.
- With `HAZARD_PERF_EN`: a single divide with DIV_CYCLES=4 → `perf_div`=4. During the divide, a simultaneous lw hazard does not increment `perf_lw`.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   FWD_REG / FWD_W / FWD_M : E-stage forward-select encodings
//   div_state_t             : divide stall FSM states
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_t;

endpackage

// File: rtl/div_stall_fsm.sv
// div_stall_fsm: holds the E stage while a multi-cycle divide occupies it.
//   clk, rst   : clock, synchronous active-high reset
//   divE       : divide instruction present in E
//   excflush   : exception flush, aborts any divide in progress
//   div_start  : one-cycle start pulse to the divider
//   div_done   : divider result valid this cycle; E advances
//   divstallE  : raw divide stall request
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    input  logic excflush,
    output logic div_start,
    output logic div_done,
    output logic divstallE
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    div_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_start = 1'b0;
        div_done  = 1'b0;
        // The start cycle stalls too, so the divide is held DIV_CYCLES cycles total.
        divstallE = divE && ((state == IDLE) || (cnt != '0));
        if (excflush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (divE) begin
                        div_start = 1'b1;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (!divE) begin
                        // Divide vanished from E: abandon without a result.
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt != '0) begin
                        cnt_nxt = cnt - CW'(1);
                    end else begin
                        div_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard unit for the five-stage MIPS pipeline.
//   Inputs : D/E source registers, E/M/W destinations and write enables,
//            load flags in E/M, branchD/jrD, divE, excflush.
//   Outputs: forwardaD/bD (M result to D compare), forwardaE/bE (E operand
//            select), stallF/D/E, flushE/M, div_start/div_done, and the raw
//            stall causes lwstallD, branchstallD, divstallE.
//   Option : define HAZARD_PERF_EN to add saturating stall counters
//            perf_lw, perf_br, perf_div.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              divE,
    input  logic              excflush,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushE,
    output logic              flushM,
    output logic              div_start,
    output logic              div_done,
    output logic              lwstallD,
    output logic              branchstallD,
    output logic              divstallE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_lw,
    output logic [31:0]       perf_br,
    output logic [31:0]       perf_div
`endif
);

    // Register 0 is hardwired, so it never participates in a hazard.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst);
        return (dst != '0) && (src == dst);
    endfunction

    div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .divE      (divE),
        .excflush  (excflush),
        .div_start (div_start),
        .div_done  (div_done),
        .divstallE (divstallE)
    );

    logic hitE_d, hitM_d;

    always_comb begin
        forwardaE = FWD_REG;
        if (regwriteM && hit(rsE, writeregM))      forwardaE = FWD_M;
        else if (regwriteW && hit(rsE, writeregW)) forwardaE = FWD_W;

        forwardbE = FWD_REG;
        if (regwriteM && hit(rtE, writeregM))      forwardbE = FWD_M;
        else if (regwriteW && hit(rtE, writeregW)) forwardbE = FWD_W;

        forwardaD = regwriteM && hit(rsD, writeregM);
        forwardbD = regwriteM && hit(rtD, writeregM);

        lwstallD = memtoregE && regwriteE &&
                   (hit(rsD, writeregE) || hit(rtD, writeregE));

        // jr reads only rs; a branch compares both rs and rt.
        hitE_d = hit(rsD, writeregE) || (branchD && hit(rtD, writeregE));
        hitM_d = hit(rsD, writeregM) || (branchD && hit(rtD, writeregM));
        branchstallD = (branchD || jrD) &&
                       ((regwriteE && hitE_d) || (memtoregM && hitM_d));

        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (excflush) begin
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (divstallE) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstallD || branchstallD) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic apply_div, apply_lw, apply_br;

    assign apply_div = !excflush && divstallE;
    assign apply_lw  = !excflush && !divstallE && lwstallD;
    assign apply_br  = !excflush && !divstallE && branchstallD;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw  <= '0;
            perf_br  <= '0;
            perf_div <= '0;
        end else begin
            if (apply_lw  && (perf_lw  != '1)) perf_lw  <= perf_lw  + 32'd1;
            if (apply_br  && (perf_br  != '1)) perf_br  <= perf_br  + 32'd1;
            if (apply_div && (perf_div != '1)) perf_div <= perf_div + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (DIV_CYCLES=4).
// Stimulus pushes expected outputs into a queue; a negedge monitor pops and
// compares. The reference model tracks a divide by how many cycles it has
// been in E ("age") rather than by a down-counter.
module tb_pipe_hazard_ctrl;
    import hazard_pkg::*;

    localparam int AW = 5;
    localparam int DC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic          branchD, jrD, divE, excflush;
    logic          forwardaD, forwardbD;
    logic [1:0]    forwardaE, forwardbE;
    logic          stallF, stallD, stallE, flushE, flushM;
    logic          div_start, div_done, lwstallD, branchstallD, divstallE;
`ifdef HAZARD_PERF_EN
    logic [31:0]   perf_lw, perf_br, perf_div;
`endif

    pipe_hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jrD(jrD), .divE(divE), .excflush(excflush),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushE(flushE), .flushM(flushM),
        .div_start(div_start), .div_done(div_done),
        .lwstallD(lwstallD), .branchstallD(branchstallD), .divstallE(divstallE)
`ifdef HAZARD_PERF_EN
        , .perf_lw(perf_lw), .perf_br(perf_br), .perf_div(perf_div)
`endif
    );

    typedef struct packed {
        logic        fad, fbd;
        logic [1:0]  fae, fbe;
        logic        sf, sd, se, fe, fm;
        logic        ds, dd, chk_dd;
        logic        lw, br, dv;
        logic [31:0] plw, pbr, pdv;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int          age;
    logic [31:0] m_plw, m_pbr, m_pdv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("forwardaD", 32'(forwardaD), 32'(e.fad));
            chk("forwardbD", 32'(forwardbD), 32'(e.fbd));
            chk("forwardaE", 32'(forwardaE), 32'(e.fae));
            chk("forwardbE", 32'(forwardbE), 32'(e.fbe));
            chk("stallF", 32'(stallF), 32'(e.sf));
            chk("stallD", 32'(stallD), 32'(e.sd));
            chk("stallE", 32'(stallE), 32'(e.se));
            chk("flushE", 32'(flushE), 32'(e.fe));
            chk("flushM", 32'(flushM), 32'(e.fm));
            chk("div_start", 32'(div_start), 32'(e.ds));
            if (e.chk_dd) chk("div_done", 32'(div_done), 32'(e.dd));
            chk("lwstallD", 32'(lwstallD), 32'(e.lw));
            chk("branchstallD", 32'(branchstallD), 32'(e.br));
            chk("divstallE", 32'(divstallE), 32'(e.dv));
`ifdef HAZARD_PERF_EN
            chk("perf_lw", perf_lw, e.plw);
            chk("perf_br", perf_br, e.pbr);
            chk("perf_div", perf_div, e.pdv);
`endif
        end
    end

    function automatic logic m(input logic [AW-1:0] src, input logic [AW-1:0] dst);
        return (dst != 0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        if (regwriteM && m(src, writeregM)) return 2'b10;
        if (regwriteW && m(src, writeregW)) return 2'b01;
        return 2'b00;
    endfunction

    // One clock cycle: predict this cycle's outputs, then advance the model.
    task automatic step();
        exp_t x;
        logic hE, hM;
        x = '0;
        x.fad = regwriteM && m(rsD, writeregM);
        x.fbd = regwriteM && m(rtD, writeregM);
        x.fae = fwd_sel(rsE);
        x.fbe = fwd_sel(rtE);
        x.lw  = memtoregE && regwriteE && (m(rsD, writeregE) || m(rtD, writeregE));
        hE = m(rsD, writeregE) || (branchD && m(rtD, writeregE));
        hM = m(rsD, writeregM) || (branchD && m(rtD, writeregM));
        x.br = (branchD || jrD) && ((regwriteE && hE) || (memtoregM && hM));
        x.dv = divE && (age < DC);
        x.ds = divE && (age == 0) && !excflush;
        x.dd = divE && (age == DC);
        x.chk_dd = !excflush;
        if (excflush) begin
            x.fe = 1'b1; x.fm = 1'b1;
        end else if (x.dv) begin
            x.sf = 1'b1; x.sd = 1'b1; x.se = 1'b1; x.fm = 1'b1;
        end else if (x.lw || x.br) begin
            x.sf = 1'b1; x.sd = 1'b1; x.fe = 1'b1;
        end
        x.plw = m_plw; x.pbr = m_pbr; x.pdv = m_pdv;
        q.push_back(x);

        @(posedge clk);
        if (rst) begin
            age = 0;
            m_plw = 0; m_pbr = 0; m_pdv = 0;
        end else begin
            if (!excflush) begin
                if (x.dv) begin
                    if (m_pdv != 32'hFFFF_FFFF) m_pdv++;
                end else begin
                    if (x.lw && m_plw != 32'hFFFF_FFFF) m_plw++;
                    if (x.br && m_pbr != 32'hFFFF_FFFF) m_pbr++;
                end
            end
            if (excflush || !divE || age == DC) age = 0;
            else age = age + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM} = '0;
        {branchD, jrD, divE, excflush} = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        age = 0; m_plw = 0; m_pbr = 0; m_pdv = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state with quiet inputs
        step();
        rst = 1'b0;
        step();

        // Load-use: lw r8 in E, r8 as rsD; next cycle it is in M and forwards to E
        idle_inputs();
        memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8;
        step();
        idle_inputs();
        regwriteM = 1; writeregM = 8; rsE = 8;
        step();

        // Forward priority M over W, and r0 never forwards
        idle_inputs();
        regwriteM = 1; regwriteW = 1; writeregM = 3; writeregW = 3; rsE = 3; rtE = 3;
        step();
        rsE = 0; rtE = 0; writeregM = 0; writeregW = 0;
        step();

        // Branch on r5 while E writes r5, then r5 in M
        idle_inputs();
        branchD = 1; rsD = 5; regwriteE = 1; writeregE = 5;
        step();
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 5;
        step();

        // Back-to-back divides, with a lw hazard present throughout
        idle_inputs();
        divE = 1; memtoregE = 1; regwriteE = 1; writeregE = 9; rtD = 9;
        repeat (2 * (DC + 1) + 1) step();
        idle_inputs();
        step();

        // excflush in cycle 2 of a divide
        divE = 1;
        step(); step();
        excflush = 1; step();
        excflush = 0; step(); step();
        idle_inputs();
        step();

        // rst in cycle 2 of a divide
        divE = 1;
        step(); step();
        rst = 1; step();
        rst = 0; step(); step();
        idle_inputs();
        step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rsD = AW'($urandom_range(0, 7)); rtD = AW'($urandom_range(0, 7));
            rsE = AW'($urandom_range(0, 7)); rtE = AW'($urandom_range(0, 7));
            writeregE = AW'($urandom_range(0, 7));
            writeregM = AW'($urandom_range(0, 7));
            writeregW = AW'($urandom_range(0, 7));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memtoregE = 1'($urandom); memtoregM = 1'($urandom);
            branchD = ($urandom_range(0, 2) == 0);
            jrD     = ($urandom_range(0, 3) == 0);
            if (divE) divE = ($urandom_range(0, 15) != 0);
            else      divE = ($urandom_range(0, 7) == 0);
            excflush = ($urandom_range(0, 23) == 0);
            rst      = ($urandom_range(0, 63) == 0);
            step();
        end
        idle_inputs();
        step();

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
